display_producto: RTL and testbench
===================================

Name: display_producto

Overview:
Output-side counterpart of the operand switch registers. Takes the signed 16-bit Booth product, converts its magnitude to BCD with a sequential double-dabble engine, and drives the board's 8-digit multiplexed seven-segment display. Sits between the multiplier result register and the top-level display pins.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit stays active (100 MHz -> 1 kHz per digit)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
producto  input  16  signed two's-complement product
load  input  1  one-cycle strobe; capture producto and start conversion
busy  output  1  high while a conversion is in progress
an  output  8  digit anodes, active low, an[0] = rightmost digit
seg  output  7  segments {g,f,e,d,c,b,a}, active low
dp  output  1  decimal point, active low; constant 1 (off)

Behaviour:
- Reset is asynchronous on rst_n low and applies to all flops.
- Reset values: busy=0; display regs bcd=0, neg=0; scan index=0; prescaler=0.
- Reset outputs: an=8'hFE; seg=7'b1000000 (shows "0"); dp=1.
- FSM states: IDLE and CONV.
- IDLE -> CONV: load sampled high in IDLE.
  - Capture neg=producto[15].
  - Capture mag = neg ? -producto : producto as 16-bit unsigned; 0x8000 gives 32768.
  - Clear the 20-bit BCD work register; iteration counter=0.
- CONV:
  - One double-dabble iteration per cycle: add 3 to every BCD nibble >=5, then shift {bcd,mag} left by 1.
  - 16 iterations total, counter 0..15.
  - On the edge that completes iteration 15: copy work BCD and neg into the display regs; return to IDLE.
- busy = (state==CONV). It is high for exactly 16 cycles, starting the cycle after load is sampled.
- Display regs change only at conversion completion, so the previously shown value is held steady during CONV.
- load while busy is ignored (no restart, no re-capture). load on the completing cycle is also ignored; a new load is accepted in IDLE only.
- Mid-conversion reset aborts the conversion; the display returns to "0".
- Scanner runs continuously and is independent of the FSM:
  - prescaler counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, the scan index increments 0..7 and wraps to 0.
  - an = ~(8'b1 << index); exactly one anode is low at all times.
- Digit content:
  - Digits 0..4 show BCD nibbles 0..4.
  - Digit 5 shows minus (7'b0111111) if neg, else blank.
  - Digits 6 and 7 are always blank (7'b1111111).
- Leading-zero blanking: digit k (1..4) is blank if nibbles k..4 are all zero. Digit 0 always shows its value, so zero displays as "0".
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles >9 never occur; if they do, decode as blank.
- seg is combinationally decoded from the registered scan index and the display regs; an is decoded from the index only.

Test Plan:
- Reset with REFRESH_DIV=4 -> busy=0; an cycles FE,FD,FB,...,7F, each for 4 clks; digit 0 seg=1000000; all other digits 1111111.
- load with producto=16'h4000 -> busy high for exactly 16 cycles, then digits 4..0 show 1,6,3,8,4; digit 5 blank.
- load with producto=16'hC080 (-16256) -> digit5 minus, digits 4..0 show 1,6,2,5,6; a previously shown value is unchanged during busy.
- load with producto=16'h8000 -> minus, 3,2,7,6,8. Then load 16'd7 -> only digit0 shows 7, digits 1..5 blank.
- Second load pulse mid-conversion with a different value -> ignored; the first value is displayed; busy length is still 16.
- rst_n low for 1 cycle at busy cycle 8 -> busy=0 immediately; display shows "0"; an=FE; the next load converts normally.

Source files
------------

// File: rtl/display_producto.sv
// display_producto: converts the signed 16-bit Booth product to sign + BCD
// magnitude with a sequential double-dabble engine and drives the board's
// 8-digit multiplexed, active-low seven-segment display.
module display_producto #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] producto,
  input  logic        load,
  output logic        busy,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int             PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [6:0]     BLANK   = 7'b1111111;
  localparam logic [6:0]     MINUS   = 7'b0111111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_n;
  logic            start_s;
  logic            done_s;

  logic [15:0]     mag_r;
  logic [15:0]     mag_in_s;
  logic [19:0]     work_r;
  logic [19:0]     adj_s;
  logic [19:0]     shift_s;
  logic [3:0]      iter_r;
  logic            neg_cap_r;

  logic [19:0]     bcd_r;
  logic            neg_r;

  logic [PW-1:0]   pre_r;
  logic [2:0]      idx_r;

  logic            nz1_s;
  logic            nz2_s;
  logic            nz3_s;
  logic            nz4_s;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit; >9 is blank.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = 7'b1111111;
    endcase
    return r;
  endfunction

  // Magnitude of the two's-complement product; 0x8000 maps to 32768 unsigned.
  assign mag_in_s = producto[15] ? (~producto + 16'd1) : producto;

  // Conversion FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic: loads are only accepted in IDLE; 16 iterations in CONV.
  always_comb begin
    state_n = state_r;
    start_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (load) begin
          state_n = CONV;
          start_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      CONV: begin
        if (iter_r == 4'd15) begin
          state_n = IDLE;
          done_s  = 1'b1;
        end else begin
          state_n = CONV;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // One double-dabble step: +3 on each nibble >=5, then shift in the next magnitude bit.
  always_comb begin
    adj_s = work_r;
    for (int i = 0; i < 5; i++) begin
      if (work_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = work_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = work_r[4*i +: 4];
      end
    end
    shift_s = {adj_s[18:0], mag_r[15]};
  end

  // Conversion datapath; display regs update only when the last iteration completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_r     <= 16'd0;
      work_r    <= 20'd0;
      iter_r    <= 4'd0;
      neg_cap_r <= 1'b0;
      bcd_r     <= 20'd0;
      neg_r     <= 1'b0;
    end else begin
      if (start_s) begin
        neg_cap_r <= producto[15];
        mag_r     <= mag_in_s;
        work_r    <= 20'd0;
        iter_r    <= 4'd0;
      end else if (state_r == CONV) begin
        work_r    <= shift_s;
        mag_r     <= {mag_r[14:0], 1'b0};
        iter_r    <= iter_r + 4'd1;
      end
      if (done_s) begin
        bcd_r <= shift_s;
        neg_r <= neg_cap_r;
      end
    end
  end

  // Free-running digit scanner: each digit stays active for REFRESH_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= '0;
      idx_r <= 3'd0;
    end else begin
      if (pre_r == PRE_MAX) begin
        pre_r <= '0;
        idx_r <= idx_r + 3'd1;
      end else begin
        pre_r <= pre_r + {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

  // A digit is significant when it or any higher nibble is non-zero.
  assign nz4_s = |bcd_r[19:16];
  assign nz3_s = |bcd_r[19:12];
  assign nz2_s = |bcd_r[19:8];
  assign nz1_s = |bcd_r[19:4];

  // Segment decode for the currently scanned digit with leading-zero blanking.
  always_comb begin
    seg = BLANK;
    case (idx_r)
      3'd0:    seg = seg_code(bcd_r[3:0]);
      3'd1:    seg = nz1_s ? seg_code(bcd_r[7:4])   : BLANK;
      3'd2:    seg = nz2_s ? seg_code(bcd_r[11:8])  : BLANK;
      3'd3:    seg = nz3_s ? seg_code(bcd_r[15:12]) : BLANK;
      3'd4:    seg = nz4_s ? seg_code(bcd_r[19:16]) : BLANK;
      3'd5:    seg = neg_r ? MINUS : BLANK;
      default: seg = BLANK;
    endcase
  end

  assign an   = ~(8'd1 << idx_r);
  assign busy = (state_r == CONV);
  assign dp   = 1'b1;

endmodule

// File: tb/tb_display_producto.sv
// Self-checking bench for display_producto with a fast scan rate (REFRESH_DIV=4).
// Expected display contents are pushed to a scoreboard queue when a load is
// driven and popped once the conversion has finished.
module tb_display_producto;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] producto = 16'd0;
  logic        load = 1'b0;
  logic        busy;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vectors = 0;
  int miscompares = 0;

  logic [55:0] exp_q[$];
  logic [55:0] shown;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  display_producto #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .producto(producto), .load(load),
    .busy(busy), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: 8 digit patterns (digit k at bits 7k+:7) for a product value.
  function automatic logic [55:0] model(input logic [15:0] p);
    logic [55:0] r;
    int v, mag, pw;
    v   = $signed(p);
    mag = (v < 0) ? -v : v;
    r   = {8{BLANK}};
    pw  = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 0 || mag >= pw) r[7*k +: 7] = seg_tab[(mag / pw) % 10];
      pw = pw * 10;
    end
    if (v < 0) r[35 +: 7] = MINUS;
    return r;
  endfunction

  // Index of the single low anode, or -1 if the anode pattern is not one-hot-low.
  function automatic int anode_idx(input logic [7:0] a);
    int idx;
    logic [7:0] m;
    idx = -1;
    for (int k = 0; k < 8; k++) begin
      m = ~(8'd1 << k);
      if (a === m) idx = k;
    end
    return idx;
  endfunction

  // Observe one full scan (32 clocks) and collect the pattern seen on each digit.
  task automatic scan_display(output logic [55:0] obs, output int an_bad);
    int idx;
    obs    = 'x;
    an_bad = 0;
    repeat (32) begin
      @(negedge clk);
      idx = anode_idx(an);
      if (idx < 0) an_bad++;
      else obs[7*idx +: 7] = seg;
    end
  endtask

  // Drive one load, optionally a stray load at busy cycle 'at', and measure busy length.
  // held_bad counts busy cycles where the shown digit differed from the prior display.
  task automatic run_load(input logic [15:0] v, input logic [15:0] v2, input int at,
                          output int cycles, output int held_bad);
    int idx;
    @(negedge clk);
    producto = v;
    load     = 1'b1;
    exp_q.push_back(model(v));
    @(negedge clk);
    load     = 1'b0;
    cycles   = 0;
    held_bad = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      idx = anode_idx(an);
      if (idx < 0 || seg !== shown[7*idx +: 7]) held_bad++;
      if (at >= 0 && cycles == at) begin
        producto = v2;
        load     = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_reset;
    int exp_idx;
    logic [7:0] exp_an;
    rst_n = 1'b0;
    shown = model(16'd0);
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (an !== 8'hFE) begin miscompares++; $display("FAIL reset_an: got %h want fe", an); end
    vectors++; if (seg !== 7'b1000000) begin miscompares++; $display("FAIL reset_seg: got %b want 1000000", seg); end
    vectors++; if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp: got %b want 1", dp); end
    rst_n = 1'b1;
    for (int n = 0; n < 36; n++) begin
      exp_idx = (n / 4) % 8;
      exp_an  = ~(8'd1 << exp_idx);
      vectors++;
      if (an !== exp_an) begin miscompares++; $display("FAIL scan_an[%0d]: got %h want %h", n, an, exp_an); end
      vectors++;
      if (seg !== shown[7*exp_idx +: 7]) begin
        miscompares++; $display("FAIL scan_seg[%0d]: got %b want %b", n, seg, shown[7*exp_idx +: 7]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_positive;
    int c, hb, ab;
    logic [55:0] obs, e;
    run_load(16'h4000, 16'h0000, -1, c, hb);
    scan_display(obs, ab);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    vectors++; if (c !== 16) begin miscompares++; $display("FAIL pos_busy_len: got %0d want 16", c); end
    vectors++; if (hb !== 0) begin miscompares++; $display("FAIL pos_held: got %0d bad cycles want 0", hb); end
    vectors++; if (ab !== 0) begin miscompares++; $display("FAIL pos_anodes: got %0d bad want 0", ab); end
    vectors++; if (obs !== e) begin miscompares++; $display("FAIL pos_digits: got %h want %h", obs, e); end
    shown = e;
  endtask

  task automatic test_negative;
    int c, hb, ab;
    logic [55:0] obs, e;
    run_load(16'hC080, 16'h0000, -1, c, hb);
    scan_display(obs, ab);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    vectors++; if (c !== 16) begin miscompares++; $display("FAIL neg_busy_len: got %0d want 16", c); end
    vectors++; if (hb !== 0) begin miscompares++; $display("FAIL neg_held: got %0d bad cycles want 0", hb); end
    vectors++; if (obs !== e) begin miscompares++; $display("FAIL neg_digits: got %h want %h", obs, e); end
    shown = e;
  endtask

  task automatic test_extremes;
    int c, hb, ab;
    logic [55:0] obs, e;
    run_load(16'h8000, 16'h0000, -1, c, hb);
    scan_display(obs, ab);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    vectors++; if (c !== 16) begin miscompares++; $display("FAIL min_busy_len: got %0d want 16", c); end
    vectors++; if (obs !== e) begin miscompares++; $display("FAIL min_digits: got %h want %h", obs, e); end
    shown = e;
    run_load(16'd7, 16'h0000, -1, c, hb);
    scan_display(obs, ab);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    vectors++; if (hb !== 0) begin miscompares++; $display("FAIL small_held: got %0d bad cycles want 0", hb); end
    vectors++; if (obs !== e) begin miscompares++; $display("FAIL small_digits: got %h want %h", obs, e); end
    shown = e;
  endtask

  task automatic test_back_to_back;
    int c, hb, ab;
    logic [55:0] obs, e;
    run_load(16'd1234, 16'd4321, 5, c, hb);
    scan_display(obs, ab);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    vectors++; if (c !== 16) begin miscompares++; $display("FAIL mid_busy_len: got %0d want 16", c); end
    vectors++; if (obs !== e) begin miscompares++; $display("FAIL mid_digits: got %h want %h", obs, e); end
    shown = e;
    run_load(16'd999, 16'd5555, 16, c, hb);
    vectors++; if (c !== 16) begin miscompares++; $display("FAIL last_busy_len: got %0d want 16", c); end
    repeat (3) begin
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL last_load_ignored: busy %b want 0", busy); end
    end
    scan_display(obs, ab);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    vectors++; if (obs !== e) begin miscompares++; $display("FAIL last_digits: got %h want %h", obs, e); end
    shown = e;
  endtask

  task automatic test_reset_abort;
    int c, hb, ab;
    logic [55:0] obs, e;
    @(negedge clk);
    producto = 16'h2A5F;
    load     = 1'b1;
    exp_q.push_back(model(16'h2A5F));
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
    vectors++; if (an !== 8'hFE) begin miscompares++; $display("FAIL abort_an: got %h want fe", an); end
    vectors++; if (seg !== 7'b1000000) begin miscompares++; $display("FAIL abort_seg: got %b want 1000000", seg); end
    exp_q.delete();
    shown = model(16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_load(16'd905, 16'h0000, -1, c, hb);
    scan_display(obs, ab);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    vectors++; if (c !== 16) begin miscompares++; $display("FAIL post_busy_len: got %0d want 16", c); end
    vectors++; if (hb !== 0) begin miscompares++; $display("FAIL post_held: got %0d bad cycles want 0", hb); end
    vectors++; if (obs !== e) begin miscompares++; $display("FAIL post_digits: got %h want %h", obs, e); end
    shown = e;
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_extremes();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
